// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM state codes,
// opcodes, ALU control codes and datapath select encodings.
package mc_ctrl_pkg;

    // FSM state encoding (4 bits, 12 states used)
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_ILLEGAL  = 4'd11;

    // Opcodes
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU A input
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU B input
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format is purely a function of the opcode
    function automatic logic [1:0] immSel(input logic [6:0] op);
        logic [1:0] sel;
        sel = IMM_I;
        case (op)
            OP_LW, OP_ITYPE: sel = IMM_I;
            OP_SW:           sel = IMM_S;
            OP_BRANCH:       sel = IMM_B;
            OP_JAL:          sel = IMM_J;
            default:         sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mc_control_alu_dec.sv
// ALU decoder: maps op[5], funct3 and funct7[5] to an ALU control code.
// Only meaningful in the execute states; the top selects it there.
import mc_ctrl_pkg::*;

module alu_dec (
    input  logic       op5,
    input  logic [2:0] f3,
    input  logic       f75,
    output logic [2:0] aluControl
);

    // funct3 selects the operation; funct7[5] distinguishes sub only for R-type
    always_comb begin
        aluControl = ALU_ADD;
        case (f3)
            3'b000:  aluControl = (op5 & f75) ? ALU_SUB : ALU_ADD;
            3'b010:  aluControl = ALU_SLT;
            3'b110:  aluControl = ALU_OR;
            3'b111:  aluControl = ALU_AND;
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode,
// execute, memory and write-back over a shared ALU and memory port.
// Optional feature macro: MC_CONTROL_BNE_EN adds bne (funct3=001) branches.
import mc_ctrl_pkg::*;

module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] immSrc,
    output logic [2:0] aluControl,
    output logic       regWrite,
    output logic       illegal
);

    localparam logic [3:0] RESET_STATE = S_FETCH;

    logic [3:0] state, nextState;
    logic [2:0] decAluControl;
    logic       branchOk;
    logic       pcWriteRaw, memWriteRaw, irWriteRaw, regWriteRaw;
    logic       unusedF7Bits;

    // Only funct7[5] matters to the decoder
    assign unusedF7Bits = ^{f7[6], f7[4:0]};

    alu_dec uAluDec (
        .op5        (op[5]),
        .f3         (f3),
        .f75        (f7[5]),
        .aluControl (decAluControl)
    );

`ifdef MC_CONTROL_BNE_EN
    assign branchOk = (f3 == 3'b000) || (f3 == 3'b001);
`else
    assign branchOk = (f3 == 3'b000);
`endif

    // State register; reset aborts any instruction back to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RESET_STATE;
        else        state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            S_FETCH:    nextState = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nextState = S_MEMADR;
                    OP_RTYPE:     nextState = S_EXECR;
                    OP_ITYPE:     nextState = S_EXECI;
                    OP_BRANCH:    nextState = branchOk ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:       nextState = S_JAL;
                    default:      nextState = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   nextState = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  nextState = S_MEMWB;
            S_MEMWB:    nextState = S_FETCH;
            S_MEMWRITE: nextState = S_FETCH;
            S_EXECR:    nextState = S_ALUWB;
            S_EXECI:    nextState = S_ALUWB;
            S_ALUWB:    nextState = S_FETCH;
            S_BRANCH:   nextState = S_FETCH;
            S_JAL:      nextState = S_ALUWB;
            S_ILLEGAL:  nextState = S_ILLEGAL;
            default:    nextState = S_FETCH;
        endcase
    end

    // Output decode; only the branch PC write looks at an input (zero)
    always_comb begin
        pcWriteRaw  = 1'b0;
        adrSrc      = 1'b0;
        memWriteRaw = 1'b0;
        irWriteRaw  = 1'b0;
        regWriteRaw = 1'b0;
        resultSrc   = RES_ALUOUT;
        aluSrcA     = SRCA_PC;
        aluSrcB     = SRCB_RS2;
        aluControl  = ALU_ADD;
        case (state)
            S_FETCH: begin
                irWriteRaw = 1'b1;
                pcWriteRaw = 1'b1;
                aluSrcA    = SRCA_PC;
                aluSrcB    = SRCB_FOUR;
                resultSrc  = RES_ALURESULT;
            end
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
            end
            S_MEMREAD: adrSrc = 1'b1;
            S_MEMWB: begin
                resultSrc   = RES_DATA;
                regWriteRaw = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc      = 1'b1;
                memWriteRaw = 1'b1;
            end
            S_EXECR: begin
                aluSrcA    = SRCA_RS1;
                aluSrcB    = SRCB_RS2;
                aluControl = decAluControl;
            end
            S_EXECI: begin
                aluSrcA    = SRCA_RS1;
                aluSrcB    = SRCB_IMM;
                aluControl = decAluControl;
            end
            S_ALUWB: regWriteRaw = 1'b1;
            S_BRANCH: begin
                aluSrcA    = SRCA_RS1;
                aluSrcB    = SRCB_RS2;
                aluControl = ALU_SUB;
`ifdef MC_CONTROL_BNE_EN
                pcWriteRaw = ((f3 == 3'b000) & zero) | ((f3 == 3'b001) & ~zero);
`else
                pcWriteRaw = (f3 == 3'b000) & zero;
`endif
            end
            S_JAL: begin
                aluSrcA    = SRCA_OLDPC;
                aluSrcB    = SRCB_FOUR;
                pcWriteRaw = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are held low for as long as reset is asserted
    assign pcWrite  = reset & pcWriteRaw;
    assign irWrite  = reset & irWriteRaw;
    assign memWrite = reset & memWriteRaw;
    assign regWrite = reset & regWriteRaw;
    assign illegal  = reset & (state == S_ILLEGAL);
    assign immSrc   = immSel(op);

endmodule

// File: tb/tb_mc_control.sv
// Randomized self-checking bench for mc_control. A per-instruction phase
// sequence plus a control-word table derived from the instruction semantics
// supplies the expected outputs each cycle.
module tb_mc_control;

    typedef logic [16:0] word_t;
    typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB, P_BR, P_JAL, P_ILL} ph_t;

`ifdef MC_CONTROL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op = '0;
    logic [2:0] f3 = '0;
    logic [6:0] f7 = '0;
    logic       zero = 1'b0;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0] aluControl;
    word_t      got;

    int nChecks = 0;
    int nErrors = 0;

    mc_control dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .f3         (f3),
        .f7         (f7),
        .zero       (zero),
        .pcWrite    (pcWrite),
        .adrSrc     (adrSrc),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .resultSrc  (resultSrc),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .immSrc     (immSrc),
        .aluControl (aluControl),
        .regWrite   (regWrite),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign got = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA,
                  aluSrcB, immSrc, aluControl, regWrite, illegal};

    task automatic check(input string tag, input word_t obs, input word_t exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %05h expected %05h (pw,as,mw,iw,rs,sa,sb,im,ac,rw,il)",
                     tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] aluRef(input logic [6:0] o, input logic [2:0] f, input logic [6:0] g);
        case (f)
            3'b000:  return (o[5] && g[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] immRef(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Expected control word for one phase of an instruction
    function automatic word_t model(input ph_t ph, input logic [6:0] o, input logic [2:0] f,
                                    input logic [6:0] g, input logic z, input bit inReset);
        logic pw = 0, as = 0, mw = 0, iw = 0, rw = 0, il = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0;
        logic [2:0] ac = 0;
        case (ph)
            P_F:   begin iw = 1; pw = 1; sb = 2; rs = 2; end
            P_D:   begin sa = 1; sb = 1; end
            P_MA:  begin sa = 2; sb = 1; end
            P_MR:  as = 1;
            P_MWB: begin rs = 1; rw = 1; end
            P_MW:  begin as = 1; mw = 1; end
            P_ER:  begin sa = 2; ac = aluRef(o, f, g); end
            P_EI:  begin sa = 2; sb = 1; ac = aluRef(o, f, g); end
            P_AWB: rw = 1;
            P_BR:  begin
                sa = 2; ac = 3'b001;
                if (f == 3'b000) pw = z;
                else if (BNE_EN && f == 3'b001) pw = !z;
            end
            P_JAL: begin sa = 1; sb = 2; pw = 1; end
            P_ILL: il = 1;
            default: ;
        endcase
        if (inReset) begin pw = 0; iw = 0; mw = 0; rw = 0; il = 0; end
        return {pw, as, mw, iw, rs, sa, sb, immRef(o), ac, rw, il};
    endfunction

    function automatic bit legalOp(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // Entered one time unit after the rising edge that starts FETCH.
    // zMode < 0 randomizes zero each cycle; abortAt >= 0 asserts reset in that phase.
    task automatic runInstr(input string name, input logic [6:0] o, input logic [2:0] f,
                            input logic [6:0] g, input int zMode, input int abortAt);
        ph_t seq[$];
        seq = '{P_F, P_D};
        case (o)
            7'b0000011: seq = '{P_F, P_D, P_MA, P_MR, P_MWB};
            7'b0100011: seq = '{P_F, P_D, P_MA, P_MW};
            7'b0110011: seq = '{P_F, P_D, P_ER, P_AWB};
            7'b0010011: seq = '{P_F, P_D, P_EI, P_AWB};
            7'b1101111: seq = '{P_F, P_D, P_JAL, P_AWB};
            7'b1100011: begin
                if (f == 3'b000 || (BNE_EN && f == 3'b001)) seq = '{P_F, P_D, P_BR};
                else seq = '{P_F, P_D, P_ILL, P_ILL, P_ILL};
            end
            default: seq = '{P_F, P_D, P_ILL, P_ILL, P_ILL};
        endcase
        op = o; f3 = f; f7 = g;
        for (int i = 0; i < seq.size(); i++) begin
            zero = (zMode < 0) ? 1'($urandom_range(0, 1)) : 1'(zMode);
            #1;
            check($sformatf("%s c%0d", name, i + 1), got, model(seq[i], o, f, g, zero, 1'b0));
            if (i == abortAt || (seq[i] == P_ILL && i == seq.size() - 1)) begin
                #1 reset = 1'b0;
                #1 check($sformatf("%s abort", name), got, model(P_F, o, f, g, zero, 1'b1));
                @(posedge clk);
                #2 check($sformatf("%s held", name), got, model(P_F, o, f, g, zero, 1'b1));
                @(posedge clk);
                #1 reset = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] o;
        logic [2:0] f;
        logic [6:0] g;
        int k;
        int ab;

        // Reset held three cycles; enables stay low throughout
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2 check($sformatf("reset c%0d", i), got, model(P_F, op, f3, f7, zero, 1'b1));
        end
        @(posedge clk);
        #1 reset = 1'b1;

        // Directed: the instruction classes and boundaries called out for this block
        runInstr("lw",     7'b0000011, 3'b010, 7'b0000000, -1, -1);
        runInstr("add",    7'b0110011, 3'b000, 7'b0000000, -1, -1);
        runInstr("sub",    7'b0110011, 3'b000, 7'b0100000, -1, -1);
        runInstr("beq z1", 7'b1100011, 3'b000, 7'b0000000,  1, -1);
        runInstr("beq z0", 7'b1100011, 3'b000, 7'b0000000,  0, -1);
        runInstr("jal",    7'b1101111, 3'b000, 7'b0000000, -1, -1);
        runInstr("sw",     7'b0100011, 3'b010, 7'b0000000, -1, -1);
        runInstr("addi20", 7'b0010011, 3'b000, 7'b0100000, -1, -1);
        runInstr("ill",    7'b1111111, 3'b000, 7'b0000000, -1, -1);
        runInstr("blt",    7'b1100011, 3'b100, 7'b0000000, -1, -1);
        runInstr("bne",    7'b1100011, 3'b001, 7'b0000000,  0, -1);
        runInstr("swAbrt", 7'b0100011, 3'b010, 7'b0000000, -1, 3);

        // Randomized instruction stream with occasional mid-instruction resets
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 7);
            f = 3'($urandom);
            g = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'($urandom);
            case (k)
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2: o = 7'b0110011;
                3: o = 7'b0010011;
                4, 5: begin
                    o = 7'b1100011;
                    k = $urandom_range(0, 3);
                    if (k < 2) f = 3'b000;
                    else if (k == 2) f = 3'b001;
                end
                6: o = 7'b1101111;
                default: begin
                    o = 7'($urandom);
                    while (legalOp(o)) o = 7'($urandom);
                end
            endcase
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4) : -1;
            runInstr($sformatf("r%0d op%07b f3%03b", n, o, f), o, f, g, -1, ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
